// File: rtl/axicb_pkg.sv
// Shared crossbar definitions: master count, B channel field offsets and
// one-hot helper used by the write switch and its arbiter.
package axicb_pkg;

  localparam int unsigned MST_NB      = 4;
  localparam int unsigned MST_IDX_W   = 2;
  localparam int unsigned BCH_BID_LSB = 0;

  // BRESP sits directly above BID in the concatenated B payload.
  function automatic int unsigned bch_bresp_lsb(input int unsigned id_w);
    return id_w;
  endfunction

  // One-hot to binary index; all-zero maps to index 0.
  function automatic logic [MST_IDX_W-1:0] oh2idx(input logic [MST_NB-1:0] oh);
    logic [MST_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MST_NB; i++) begin
      if (oh[i]) idx = idx | MST_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axicb_rr_arbiter.sv
// Round-robin arbiter with grant lock.
// Ports: aclk/aresetn/srst, req (per-master request), en (grant accepted:
// advance pointer past winner, release lock), stall (grant presented but not
// accepted: freeze current grant), grant (one-hot, combinational).
import axicb_pkg::*;

module axicb_rr_arbiter (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic [MST_NB-1:0] req,
  input  logic              en,
  input  logic              stall,
  output logic [MST_NB-1:0] grant
);

  logic [MST_IDX_W-1:0] ptr_q;
  logic                 lock_q;
  logic [MST_NB-1:0]    lock_grant_q;
  logic [MST_NB-1:0]    rr_grant;
  logic [MST_IDX_W-1:0] idx;
  logic                 found;

  // Search for the first requester starting at the priority pointer.
  always_comb begin
    rr_grant = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 0; k < MST_NB; k++) begin
      idx = MST_IDX_W'(ptr_q + MST_IDX_W'(k));
      if (!found && req[idx]) begin
        rr_grant[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign grant = lock_q ? lock_grant_q : rr_grant;

  // Pointer and lock state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q        <= '0;
      lock_q       <= 1'b0;
      lock_grant_q <= '0;
    end else if (srst) begin
      ptr_q        <= '0;
      lock_q       <= 1'b0;
      lock_grant_q <= '0;
    end else if (en) begin
      ptr_q  <= MST_IDX_W'(oh2idx(grant) + MST_IDX_W'(1));
      lock_q <= 1'b0;
    end else if (stall && !lock_q) begin
      lock_q       <= 1'b1;
      lock_grant_q <= grant;
    end
  end

endmodule

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO.
// Ports: aclk/aresetn/srst, push/data_in, pop/data_out, full, empty.
// With PASS_THRU=0 a pushed word becomes visible on data_out the cycle after
// the push. Pop on empty is ignored; push on full is accepted only together
// with a pop.
module axicb_scfifo #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PASS_THRU  = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_q;
  logic [PTR_W-1:0]      rd_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign data_out = (PASS_THRU != 0 && empty) ? data_in : mem[rd_q];

  // Storage array, no reset needed.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_q] <= data_in;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (srst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= PTR_W'(wr_q + PTR_W'(1));
      if (do_pop)  rd_q <= PTR_W'(rd_q + PTR_W'(1));
      case ({do_push, do_pop})
        2'b10:   cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
        2'b01:   cnt_q <= CNT_W'(cnt_q - CNT_W'(1));
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axicb_mst_switch_wr.sv
// Slave-side write switch: merges AW/W from up to four masters into one slave.
// AW is arbitrated round-robin, grant order is queued so W bursts follow AW
// order, and B responses are steered back by matching BID against per-master
// ID masks.
// Ports: aclk/aresetn/srst; i_aw*/i_w*/i_b* master-facing (per master,
// i_bch broadcast); o_aw*/o_w*/o_b* slave-facing.
module axicb_mst_switch_wr #(
  parameter int unsigned AXI_ADDR_W      = 8,
  parameter int unsigned AXI_ID_W        = 8,
  parameter int unsigned MST_NB          = 4,
  parameter int unsigned MST_OSTDREQ_NUM = 4,
  parameter logic [AXI_ID_W-1:0] MST0_ID_MASK = 'h10,
  parameter logic [AXI_ID_W-1:0] MST1_ID_MASK = 'h20,
  parameter logic [AXI_ID_W-1:0] MST2_ID_MASK = 'h40,
  parameter logic [AXI_ID_W-1:0] MST3_ID_MASK = 'h80,
  parameter int unsigned AWCH_W          = 8,
  parameter int unsigned WCH_W           = 8,
  parameter int unsigned BCH_W           = 10
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic [MST_NB-1:0]        i_awvalid,
  output logic [MST_NB-1:0]        i_awready,
  input  logic [MST_NB*AWCH_W-1:0] i_awch,
  input  logic [MST_NB-1:0]        i_wvalid,
  output logic [MST_NB-1:0]        i_wready,
  input  logic [MST_NB-1:0]        i_wlast,
  input  logic [MST_NB*WCH_W-1:0]  i_wch,
  output logic [MST_NB-1:0]        i_bvalid,
  input  logic [MST_NB-1:0]        i_bready,
  output logic [BCH_W-1:0]         i_bch,
  output logic                     o_awvalid,
  input  logic                     o_awready,
  output logic [AWCH_W-1:0]        o_awch,
  output logic                     o_wvalid,
  input  logic                     o_wready,
  output logic                     o_wlast,
  output logic [WCH_W-1:0]         o_wch,
  input  logic                     o_bvalid,
  output logic                     o_bready,
  input  logic [BCH_W-1:0]         o_bch
);

  import axicb_pkg::oh2idx;
  import axicb_pkg::MST_IDX_W;
  import axicb_pkg::BCH_BID_LSB;

  localparam logic [MST_NB*AXI_ID_W-1:0] ID_MASKS =
    {MST3_ID_MASK, MST2_ID_MASK, MST1_ID_MASK, MST0_ID_MASK};

  // The AW payload is expected to carry at least the address.
  if (AWCH_W < AXI_ADDR_W) begin : g_awch_narrow
  end

  logic                 act;
  logic [MST_NB-1:0]    aw_grant;
  logic [MST_IDX_W-1:0] aw_idx;
  logic                 aw_req;
  logic                 aw_hs;
  logic                 aw_stall;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [MST_NB-1:0]    fifo_dout;
  logic [MST_NB-1:0]    w_head;
  logic [MST_IDX_W-1:0] w_idx;
  logic [AXI_ID_W-1:0]  bid;
  logic [MST_NB-1:0]    b_sel;
  logic [MST_IDX_W-1:0] b_idx;
  logic                 b_any;

  // Handshake outputs are forced low while either reset is active.
  assign act = aresetn & ~srst;

  axicb_rr_arbiter u_arb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .req     (i_awvalid),
    .en      (aw_hs),
    .stall   (aw_stall),
    .grant   (aw_grant)
  );

  // AW: granted master straight through, blocked while grant queue is full.
  assign aw_idx    = oh2idx(aw_grant);
  assign aw_req    = |(aw_grant & i_awvalid);
  assign o_awvalid = act & aw_req & ~fifo_full;
  assign i_awready = (act & o_awready & ~fifo_full) ? aw_grant : '0;
  assign o_awch    = i_awch[32'(aw_idx)*AWCH_W +: AWCH_W];
  assign aw_hs     = o_awvalid & o_awready;
  assign aw_stall  = o_awvalid & ~o_awready;

  axicb_scfifo #(
    .DATA_WIDTH (MST_NB),
    .DEPTH      (MST_OSTDREQ_NUM),
    .PASS_THRU  (0)
  ) u_grant_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .push     (aw_hs),
    .data_in  (aw_grant),
    .pop      (fifo_pop),
    .data_out (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // W: oldest granted master owns the slave W channel until its last beat.
  assign w_head   = fifo_empty ? '0 : fifo_dout;
  assign w_idx    = oh2idx(w_head);
  assign o_wvalid = act & ~fifo_empty & i_wvalid[w_idx];
  assign o_wlast  = act & ~fifo_empty & i_wlast[w_idx];
  assign o_wch    = i_wch[32'(w_idx)*WCH_W +: WCH_W];
  assign i_wready = (act & ~fifo_empty & o_wready) ? w_head : '0;
  assign fifo_pop = o_wvalid & o_wready & o_wlast;

  // B: lowest-index master whose mask bits are all set in BID owns the response.
  assign bid = o_bch[BCH_BID_LSB +: AXI_ID_W];

  always_comb begin
    b_sel = '0;
    b_idx = '0;
    b_any = 1'b0;
    for (int i = 0; i < MST_NB; i++) begin
      if (!b_any &&
          ((bid & ID_MASKS[i*AXI_ID_W +: AXI_ID_W]) == ID_MASKS[i*AXI_ID_W +: AXI_ID_W])) begin
        b_sel[i] = 1'b1;
        b_idx    = MST_IDX_W'(i);
        b_any    = 1'b1;
      end
    end
  end

  // Unowned responses are accepted and dropped so the slave never stalls.
  assign i_bvalid = (act & o_bvalid) ? b_sel : '0;
  assign o_bready = act & (b_any ? i_bready[b_idx] : 1'b1);
  assign i_bch    = o_bch;

endmodule

// File: tb/tb_axicb_mst_switch_wr.sv
// Directed bench for axicb_mst_switch_wr: AW round-robin and lock, grant queue
// fill/drain, W ordering, B steering, asynchronous and synchronous reset.
module tb_axicb_mst_switch_wr;

  localparam int unsigned NB     = 4;
  localparam int unsigned AWCH_W = 8;
  localparam int unsigned WCH_W  = 8;
  localparam int unsigned BCH_W  = 10;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic                 srst;
  logic [NB-1:0]        i_awvalid;
  logic [NB-1:0]        i_awready;
  logic [NB*AWCH_W-1:0] i_awch;
  logic [NB-1:0]        i_wvalid;
  logic [NB-1:0]        i_wready;
  logic [NB-1:0]        i_wlast;
  logic [NB*WCH_W-1:0]  i_wch;
  logic [NB-1:0]        i_bvalid;
  logic [NB-1:0]        i_bready;
  logic [BCH_W-1:0]     i_bch;
  logic                 o_awvalid;
  logic                 o_awready;
  logic [AWCH_W-1:0]    o_awch;
  logic                 o_wvalid;
  logic                 o_wready;
  logic                 o_wlast;
  logic [WCH_W-1:0]     o_wch;
  logic                 o_bvalid;
  logic                 o_bready;
  logic [BCH_W-1:0]     o_bch;

  int nvec = 0;
  int nmis = 0;

  axicb_mst_switch_wr dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .i_awvalid (i_awvalid),
    .i_awready (i_awready),
    .i_awch    (i_awch),
    .i_wvalid  (i_wvalid),
    .i_wready  (i_wready),
    .i_wlast   (i_wlast),
    .i_wch     (i_wch),
    .i_bvalid  (i_bvalid),
    .i_bready  (i_bready),
    .i_bch     (i_bch),
    .o_awvalid (o_awvalid),
    .o_awready (o_awready),
    .o_awch    (o_awch),
    .o_wvalid  (o_wvalid),
    .o_wready  (o_wready),
    .o_wlast   (o_wlast),
    .o_wch     (o_wch),
    .o_bvalid  (o_bvalid),
    .o_bready  (o_bready),
    .o_bch     (o_bch)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_awvalid"}, 32'(o_awvalid), 0);
    chk({tag, "_wvalid"},  32'(o_wvalid),  0);
    chk({tag, "_wlast"},   32'(o_wlast),   0);
    chk({tag, "_awready"}, 32'(i_awready), 0);
    chk({tag, "_wready"},  32'(i_wready),  0);
    chk({tag, "_bvalid"},  32'(i_bvalid),  0);
    chk({tag, "_bready"},  32'(o_bready),  0);
  endtask

  initial begin
    // Reset with every input asserted: outputs must still be quiet.
    aresetn   = 1'b0;
    srst      = 1'b0;
    i_awvalid = 4'hF;
    i_awch    = 32'hA3A2A1A0;
    i_wvalid  = 4'hF;
    i_wlast   = 4'hF;
    i_wch     = 32'hB3B2B1B0;
    i_bready  = 4'hF;
    o_awready = 1'b1;
    o_wready  = 1'b1;
    o_bvalid  = 1'b1;
    o_bch     = 10'h221;
    step();
    step();
    #1;
    chk_all_quiet("rst");

    // Release with all four masters requesting: grants 0,1,2,3 back to back.
    o_bvalid = 1'b0;
    i_wvalid = 4'h0;
    o_wready = 1'b0;
    aresetn  = 1'b1;
    #1;
    chk("aw_g0_rdy",  32'(i_awready), 32'h1);
    chk("aw_g0_vld",  32'(o_awvalid), 32'h1);
    chk("aw_g0_ch",   32'(o_awch),    32'hA0);
    step();
    chk("aw_g1_rdy",  32'(i_awready), 32'h2);
    chk("aw_g1_ch",   32'(o_awch),    32'hA1);
    step();
    chk("aw_g2_rdy",  32'(i_awready), 32'h4);
    chk("aw_g2_ch",   32'(o_awch),    32'hA2);
    step();
    chk("aw_g3_rdy",  32'(i_awready), 32'h8);
    chk("aw_g3_ch",   32'(o_awch),    32'hA3);
    step();
    // Queue full after four outstanding bursts.
    chk("full_vld",   32'(o_awvalid), 32'h0);
    chk("full_rdy",   32'(i_awready), 32'h0);

    // Master 2 requests while full; master 0's one-beat burst drains one slot.
    i_awvalid = 4'b0100;
    o_wready  = 1'b1;
    i_wvalid  = 4'hF;
    i_wlast   = 4'hF;
    #1;
    chk("full_m2_rdy", 32'(i_awready), 32'h0);
    chk("w0_vld",      32'(o_wvalid),  32'h1);
    chk("w0_rdy",      32'(i_wready),  32'h1);
    chk("w0_ch",       32'(o_wch),     32'hB0);
    step();
    // Slot freed: AW accepted the cycle after the pop; W held off meanwhile.
    o_wready = 1'b0;
    #1;
    chk("resume_vld",  32'(o_awvalid), 32'h1);
    chk("resume_rdy",  32'(i_awready), 32'h4);
    chk("resume_ch",   32'(o_awch),    32'hA2);
    chk("w1_hold_rdy", 32'(i_wready),  32'h0);
    chk("w1_hold_ch",  32'(o_wch),     32'hB1);
    step();

    // Drain queue [m1,m2,m3,m2] one beat each.
    i_awvalid = 4'h0;
    o_wready  = 1'b1;
    #1;
    chk("drain_m1", 32'(i_wready), 32'h2);
    step();
    chk("drain_m2", 32'(i_wready), 32'h4);
    chk("drain_m2_ch", 32'(o_wch), 32'hB2);
    step();
    chk("drain_m3", 32'(i_wready), 32'h8);
    step();
    chk("drain_m2b", 32'(i_wready), 32'h4);
    step();
    chk("drain_empty_vld", 32'(o_wvalid), 32'h0);
    chk("drain_empty_rdy", 32'(i_wready), 32'h0);
    i_wvalid = 4'h0;
    o_wready = 1'b0;

    // Grant lock: m1 stalled 3 cycles while m0 (next in rotation) requests.
    o_awready = 1'b0;
    i_awvalid = 4'b0010;
    #1;
    chk("lock_c1_vld", 32'(o_awvalid), 32'h1);
    chk("lock_c1_rdy", 32'(i_awready), 32'h0);
    chk("lock_c1_ch",  32'(o_awch),    32'hA1);
    step();
    i_awvalid = 4'b0011;
    #1;
    chk("lock_c2_ch",  32'(o_awch),    32'hA1);
    chk("lock_c2_rdy", 32'(i_awready), 32'h0);
    step();
    chk("lock_c3_ch",  32'(o_awch),    32'hA1);
    step();
    o_awready = 1'b1;
    #1;
    chk("lock_c4_rdy", 32'(i_awready), 32'h2);
    chk("lock_c4_ch",  32'(o_awch),    32'hA1);
    step();
    chk("unlock_rdy",  32'(i_awready), 32'h1);
    chk("unlock_ch",   32'(o_awch),    32'hA0);
    i_awvalid = 4'h0;
    // Retire m1's queued burst.
    i_wvalid = 4'hF;
    i_wlast  = 4'hF;
    o_wready = 1'b1;
    step();
    chk("lock_drain_empty", 32'(o_wvalid), 32'h0);

    // W ordering: AW m2 then AW m0; m0's data is ready first but must wait.
    i_awvalid = 4'b0100;
    i_wvalid  = 4'b0101;
    i_wlast   = 4'h0;
    #1;
    chk("ord_aw_m2",   32'(i_awready), 32'h4);
    chk("ord_early_w", 32'(i_wready),  32'h0);
    chk("ord_early_v", 32'(o_wvalid),  32'h0);
    step();
    i_awvalid = 4'b0001;
    i_wvalid  = 4'b0001;
    #1;
    chk("ord_aw_m0",    32'(i_awready), 32'h1);
    chk("ord_m0_stall", 32'(o_wvalid),  32'h0);
    chk("ord_head_m2",  32'(i_wready),  32'h4);
    step();
    i_awvalid = 4'h0;
    for (int b = 0; b < 4; b++) begin
      i_wvalid       = 4'b0101;
      i_wch[16 +: 8] = 8'(8'h20 + b);
      i_wlast        = (b == 3) ? 4'b0100 : 4'b0000;
      #1;
      chk("ord_m2_vld",  32'(o_wvalid), 32'h1);
      chk("ord_m2_rdy",  32'(i_wready), 32'h4);
      chk("ord_m2_ch",   32'(o_wch),    32'(8'h20 + b));
      chk("ord_m2_last", 32'(o_wlast),  (b == 3) ? 32'h1 : 32'h0);
      step();
    end
    for (int b = 0; b < 2; b++) begin
      i_wvalid      = 4'b0001;
      i_wch[0 +: 8] = 8'(8'h30 + b);
      i_wlast       = (b == 1) ? 4'b0001 : 4'b0000;
      #1;
      chk("ord_m0_rdy",  32'(i_wready), 32'h1);
      chk("ord_m0_ch",   32'(o_wch),    32'(8'h30 + b));
      chk("ord_m0_last", 32'(o_wlast),  (b == 1) ? 32'h1 : 32'h0);
      step();
    end
    chk("ord_done_empty", 32'(o_wvalid), 32'h0);
    i_wvalid = 4'h0;
    i_wlast  = 4'h0;
    i_wch    = 32'hB3B2B1B0;

    // B steering.
    o_bvalid = 1'b1;
    o_bch    = 10'h221;
    i_bready = 4'b0010;
    #1;
    chk("b21_vld", 32'(i_bvalid), 32'h2);
    chk("b21_rdy", 32'(o_bready), 32'h1);
    chk("b21_ch",  32'(i_bch),    32'h221);
    i_bready = 4'b1101;
    #1;
    chk("b21_rdy_lo", 32'(o_bready), 32'h0);
    o_bch = 10'h001;
    #1;
    chk("b01_vld", 32'(i_bvalid), 32'h0);
    chk("b01_rdy", 32'(o_bready), 32'h1);
    o_bch    = 10'h030;
    i_bready = 4'b0001;
    #1;
    chk("b30_vld", 32'(i_bvalid), 32'h1);
    chk("b30_rdy", 32'(o_bready), 32'h1);
    i_bready = 4'b1110;
    #1;
    chk("b30_rdy_lo", 32'(o_bready), 32'h0);
    o_bvalid = 1'b0;
    #1;
    chk("b_idle_vld", 32'(i_bvalid), 32'h0);

    // Asynchronous reset mid-burst (pointer is at 2 before reset).
    i_awvalid = 4'b0010;
    #1;
    chk("mid_aw_m1", 32'(i_awready), 32'h2);
    step();
    i_awvalid = 4'h0;
    i_wvalid  = 4'b0010;
    i_wlast   = 4'h0;
    #1;
    chk("mid_w_m1", 32'(i_wready), 32'h2);
    step();
    i_awvalid = 4'hF;
    i_wvalid  = 4'hF;
    i_wlast   = 4'hF;
    o_bvalid  = 1'b1;
    o_bch     = 10'h021;
    i_bready  = 4'hF;
    aresetn   = 1'b0;
    #1;
    chk_all_quiet("arst");
    step();
    aresetn = 1'b1;
    #1;
    chk("arst_ptr0",  32'(i_awready), 32'h1);
    chk("arst_empty", 32'(o_wvalid),  32'h0);
    chk("arst_bdy",   32'(o_bready),  32'h1);
    i_wvalid  = 4'h0;
    i_awvalid = 4'b0010;
    step();

    // Synchronous reset with m1 queued and pointer at 2.
    srst     = 1'b1;
    i_wvalid = 4'hF;
    #1;
    chk("srst_wvld",  32'(o_wvalid),  32'h0);
    chk("srst_awvld", 32'(o_awvalid), 32'h0);
    chk("srst_bdy",   32'(o_bready),  32'h0);
    step();
    srst      = 1'b0;
    i_awvalid = 4'hF;
    #1;
    chk("srst_ptr0",  32'(i_awready), 32'h1);
    chk("srst_empty", 32'(o_wvalid),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/axicb_mst_switch_wr.md
# axicb_mst_switch_wr

Slave-side write switch of the AXI crossbar: sits in front of one slave agent and merges the AW/W traffic of up to four master-side write switches into that slave. Arbitrates AW requests round-robin, records the grant order in a FIFO so W bursts follow AW order, and routes each B response back to its originating master by decoding the BID against per-master ID masks.

## Interface

- AXI_ADDR_W, 8, address width in bits
- AXI_ID_W, 8, ID width in bits
- MST_NB, 4, number of masters (fixed at 4)
- MST_OSTDREQ_NUM, 4, grant FIFO depth (outstanding write bursts); power of two, ≥2
- MST0_ID_MASK .. MST3_ID_MASK, 'h10/'h20/'h40/'h80, ID ownership mask per master
- AWCH_W / WCH_W / BCH_W, 8 / 8 / 10, concatenated channel widths; BCH = {BRESP[1:0], BID}
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset
- i_awvalid / i_awready  in / out  MST_NB  per-master AW handshake
- i_awch  in  MST_NB*AWCH_W  per-master AW payload
- i_wvalid / i_wready / i_wlast  in / out / in  MST_NB  per-master W handshake
- i_wch  in  MST_NB*WCH_W  per-master W payload
- i_bvalid / i_bready  out / in  MST_NB  per-master B handshake
- i_bch  out  BCH_W  B payload, broadcast to all masters
- o_awvalid / o_awready / o_awch  out / in / out  1 / 1 / AWCH_W  slave AW
- o_wvalid / o_wready / o_wlast / o_wch  out / in / out / out  1 / 1 / 1 / WCH_W  slave W
- o_bvalid / o_bready / o_bch  in / out / in  1 / 1 / BCH_W  slave B

## Operation

- AW arbiter: round-robin over i_awvalid, priority pointer starts at master 0 after reset; the candidate search begins at pointer.
- Grant lock: once o_awvalid is asserted without o_awready, grant is held (lock register) until handshake; no switching, payload stable.
- o_awvalid = granted i_awvalid & !fifo_full; i_awready[g] = o_awready & !fifo_full, others 0; o_awch = granted payload (master 0 payload when idle).
- On AW handshake: push one-hot grant into grant FIFO; pointer ← winner+1 mod 4; lock cleared.
- W routing: FIFO head selects master; o_wvalid = !empty & i_wvalid[head]; i_wready[head] = !empty & o_wready; o_wlast/o_wch muxed from head. Pop on o_wvalid & o_wready & o_wlast. Empty → o_wvalid=0, all i_wready=0.
- B routing: master i matches when (BID & MSTi_ID_MASK) == MSTi_ID_MASK; lowest index wins. i_bvalid[i] = o_bvalid & match_i; o_bready = i_bready[matched]; i_bch = o_bch.
- No match: o_bready=1, response silently dropped (no deadlock).

## Timing

- Reset (aresetn low or srst): pointer=0, lock=0, FIFO empty; o_awvalid=0, o_wvalid=0, o_wlast=0, all i_awready/i_wready/i_bvalid=0, o_bready=0.
- AW path combinational: 0-cycle valid/ready latency.
- W for a burst usable ≥1 cycle after its AW handshake (FIFO not pass-through); W arriving earlier is stalled (i_wready=0).
- Full FIFO: o_awvalid and all i_awready deasserted; resume cycle after a pop.
- Simultaneous push and pop at full or empty: both honoured, count unchanged (empty: push wins next cycle).
- Last beat pop and next head switch in same cycle: next head active next cycle.
- B path purely combinational; no state.
- aresetn asserted mid-burst: all state cleared immediately; in-flight bursts lost.

## Structure

- Shared package axicb_pkg: MST_NB constant, BCH field offsets (BRESP at [AXI_ID_W+:2], BID at [0+:AXI_ID_W]).
- Sub-module axicb_rr_arbiter (MST_NB req in, one-hot grant out, en input to advance pointer, lock handled inside).
- Grant FIFO: instance of existing axicb_scfifo, PASS_THRU=0, DATA_WIDTH=MST_NB, depth from MST_OSTDREQ_NUM.

## Test plan

- All four masters assert AW at reset exit, o_awready=1 → grants 0,1,2,3 on consecutive cycles, FIFO holds 4'b0001,0010,0100,1000.
- Master 1 AW, o_awready=0 for 3 cycles while master 0 raises valid → grant stays 1, o_awch stable, handshake on cycle 4.
- AW m2 (len 4), AW m0 (len 2), W of m0 first → m0 stalled until m2's 4 beats with wlast complete, then m0 beats pass.
- Issue MST_OSTDREQ_NUM AWs with no W → next AW sees i_awready=0; one W burst completes → AW accepted next cycle.
- o_bvalid with BID='h21 → i_bvalid[0]=0, i_bvalid[1]=1, o_bready follows i_bready[1]; BID='h01 → dropped, o_bready=1.
- Assert aresetn low mid-burst → all outputs 0 listed above, pointer back to master 0 on release.
